jt51_logsin: RTL

JT51_LOGSIN -- requirements
Module: jt51_logsin

---
 rtl/jt51_logsin_pkg.sv | 26 ++
 rtl/jt51_logsin_if.sv | 23 ++
 rtl/jt51_logsin_rom.sv | 34 +++
 rtl/jt51_logsin.sv | 74 +++++++
 4 files changed

// File: rtl/jt51_logsin_pkg.sv
// jt51 log-sine stage: shared widths, pipeline bundle and the
// elaboration-time generator for the quarter-wave log-sine table.
package jt51_logsin_pkg;

    localparam int LOGSIN_W = 12;
    localparam int LOGATT_W = 13;
    localparam int PHASE_W  = 10;
    localparam int EG_W     = 10;
    localparam int ADDR_W   = 8;

    typedef struct packed {
        logic            v;
        logic            s;
        logic [EG_W-1:0] atten;
    } ctl_t;

    // Evaluated only with constant arguments, so the table is fixed.
    function automatic logic [LOGSIN_W-1:0] logsin_val(input int i);
        real x;
        real y;
        x = $sin((2.0 * i + 1.0) * 3.141592653589793 / 1024.0);
        y = -$ln(x) / $ln(2.0) * 256.0;
        return LOGSIN_W'($rtoi(y + 0.5));
    endfunction

endpackage

// File: rtl/jt51_logsin_if.sv
// Operator-side bundle: phase/attenuation in, log attenuation out.
// master drives the request, slave (the log-sine block) the result.
interface jt51_logsin_if;
    import jt51_logsin_pkg::*;

    logic [PHASE_W-1:0]  phase;
    logic [EG_W-1:0]     eg_atten;
    logic                in_valid;
    logic [LOGATT_W-1:0] logatt;
    logic                sign;
    logic                out_valid;

    modport master (
        output phase, eg_atten, in_valid,
        input  logatt, sign, out_valid
    );

    modport slave (
        input  phase, eg_atten, in_valid,
        output logatt, sign, out_valid
    );

endinterface

// File: rtl/jt51_logsin_rom.sv
// Quarter-wave -log2(sin) table with a cen-gated registered output;
// this register is the second pipeline stage.
module jt51_logsin_rom
    import jt51_logsin_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen,
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [LOGSIN_W-1:0] data_o
);

    logic [LOGSIN_W-1:0] rom [2**ADDR_W];
    logic [LOGSIN_W-1:0] data_q;
    logic [LOGSIN_W-1:0] data_d;

    for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_rom
        localparam logic [LOGSIN_W-1:0] V = logsin_val(g);
        assign rom[g] = V;
    end

    assign data_d = rom[addr_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (cen) begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/jt51_logsin.sv
// jt51 log-sine stage: phase fold, table lookup and envelope add
// in a three-deep cen-gated pipeline.
module jt51_logsin
    import jt51_logsin_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    input logic          cen,
    jt51_logsin_if.slave bus
);

    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    ctl_t                s1_q;
    ctl_t                s1_d;
    ctl_t                s2_q;
    logic [LOGSIN_W-1:0] lsin;
    logic [LOGATT_W-1:0] logatt_q;
    logic [LOGATT_W-1:0] logatt_d;
    logic                sign_q;
    logic                vld_q;

    // Second half of each half-wave reads the table backwards.
    always_comb begin
        addr_d = bus.phase[8] ? ~bus.phase[7:0] : bus.phase[7:0];
        s1_d   = '{v: bus.in_valid, s: bus.phase[9], atten: bus.eg_atten};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            s1_q   <= '0;
        end else if (cen) begin
            addr_q <= addr_d;
            s1_q   <= s1_d;
        end
    end

    jt51_logsin_rom u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .addr_i (addr_q),
        .data_o (lsin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= '0;
        end else if (cen) begin
            s2_q <= s1_q;
        end
    end

    // Worst case 2137 + 4092 fits in 13 bits, so no saturation.
    assign logatt_d = {1'b0, lsin} + {1'b0, s2_q.atten, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            logatt_q <= '0;
            sign_q   <= 1'b0;
            vld_q    <= 1'b0;
        end else if (cen) begin
            logatt_q <= logatt_d;
            sign_q   <= s2_q.s;
            vld_q    <= s2_q.v;
        end
    end

    assign bus.logatt    = logatt_q;
    assign bus.sign      = sign_q;
    assign bus.out_valid = vld_q;

endmodule
